// File: rtl/ad100_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ad100_mem_arbiter
//   Shares one single-port, word-addressed RAM between the CPU instruction
//   fetch port (if_*) and the load/store port (d_*). One access per cycle.
//   The data port normally wins a collision. A starvation counter gives the
//   fetch port the grant after STARVE_MAX consecutive data wins while fetch
//   was waiting. Read data comes back a fixed one cycle after the grant. It
//   is steered to the port that issued the read.
//
// Ports
//   clk_i, reset_i      clock, synchronous active-high reset
//   if_req_i/addr_i     fetch request (held until if_gnt_o)
//   if_gnt_o            fetch accepted this cycle (combinational)
//   if_rvalid_o/rdata_o fetch read return
//   d_req_i/we_i/be_i/addr_i/wdata_i  load/store request (held until d_gnt_o)
//   d_gnt_o             data accepted this cycle (combinational)
//   d_rvalid_o/rdata_o  load read return
//   mem_en_o/we_o/addr_o/wdata_o/rdata_i  RAM side
// ----------------------------------------------------------------------------
module ad100_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_W-1:0]     if_rdata_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [DATA_W/8-1:0]   d_be_i,
    input  logic [ADDR_W-1:0]     d_addr_i,
    input  logic [DATA_W-1:0]     d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DATA_W-1:0]     d_rdata_o,
    output logic                  mem_en_o,
    output logic [DATA_W/8-1:0]   mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    localparam int          BE_W = DATA_W / 8;
    localparam logic [3:0]  SMAX = 4'(STARVE_MAX);

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;

    owner_e     rd_owner_q, rd_owner_d;
    logic [3:0] starve_q, starve_d;

    // Grant decision. Reset masks both grants, and through them the RAM enable.
    always_comb begin
        if_gnt_o = 1'b0;
        d_gnt_o  = 1'b0;
        if (!reset_i) begin
            if (d_req_i && (!if_req_i || (starve_q < SMAX))) begin
                d_gnt_o = 1'b1;
            end else if (if_req_i) begin
                if_gnt_o = 1'b1;
            end
        end
    end

    // RAM drive. The address and write data are zeroed when the RAM is idle.
    always_comb begin
        mem_en_o    = if_gnt_o | d_gnt_o;
        mem_we_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (d_gnt_o) begin
            mem_addr_o = d_addr_i;
            if (d_we_i) begin
                mem_we_o = d_be_i;
            end
        end else if (if_gnt_o) begin
            mem_addr_o = if_addr_i;
        end
        if (mem_en_o) begin
            mem_wdata_o = d_wdata_i;
        end
    end

    // Starvation count and read-return owner, next-state.
    always_comb begin
        starve_d = 4'd0;
        if (d_gnt_o && if_req_i) begin
            starve_d = (starve_q == SMAX) ? starve_q : starve_q + 4'd1;
        end

        rd_owner_d = OWN_NONE;
        if (if_gnt_o) begin
            rd_owner_d = OWN_IF;
        end else if (d_gnt_o && !d_we_i) begin
            rd_owner_d = OWN_D;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_q   <= 4'd0;
            rd_owner_q <= OWN_NONE;
        end else begin
            starve_q   <= starve_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Gate the valids with reset. A read granted just before reset then never
    // signals valid in the cycle where reset rises.
    assign if_rvalid_o = (rd_owner_q == OWN_IF) && !reset_i;
    assign d_rvalid_o  = (rd_owner_q == OWN_D)  && !reset_i;
    assign if_rdata_o  = mem_rdata_i;
    assign d_rdata_o   = mem_rdata_i;

    logic unused_be_w;
    assign unused_be_w = (BE_W == DATA_W / 8);

endmodule

// File: tb/tb_ad100_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ad100_mem_arbiter
//   Directed and randomized bench for the arbiter. A simple RAM model sits on
//   the mem_* side. The reference model predicts grants from the priority and
//   starvation rules. It keeps its own copy of the memory contents to predict
//   read data. Every prediction is compared against the DUT each cycle.
// ----------------------------------------------------------------------------
module tb_ad100_mem_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int SM     = 4;
    localparam int BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              ireq;
    logic [ADDR_W-1:0] iaddr;
    logic              dreq, dwe;
    logic [BE_W-1:0]   dbe;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dwd;

    logic              if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en;
    logic [DATA_W-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [BE_W-1:0]   mem_we;
    logic [ADDR_W-1:0] mem_addr;

    ad100_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SM)) dut (
        .clk_i(clk), .reset_i(rst),
        .if_req_i(ireq), .if_addr_i(iaddr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(dreq), .d_we_i(dwe), .d_be_i(dbe), .d_addr_i(daddr),
        .d_wdata_i(dwd), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM environment. It has a preload port so that this block is the only writer.
    logic [DATA_W-1:0] ram [32];
    logic              pre_en;
    logic [4:0]        pre_addr;
    logic [DATA_W-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (mem_we[b]) ram[mem_addr[4:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            if (mem_we == '0) mem_rdata <= ram[mem_addr[4:0]];
        end
    end

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [32];
    int                wins;          // consecutive data wins while fetch waited
    int                pend;          // 0 none, 1 fetch read due, 2 load read due
    logic [DATA_W-1:0] pend_data;
    logic              act_i, act_d, last_i, last_d;
    int                checks = 0;
    int                errors = 0;
    logic [9:0]        pattern;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Inputs are already driven. Combinational outputs are
    // checked mid-cycle, and the model advances at the rising edge.
    task automatic step();
        logic              eg_i, eg_d;
        logic [ADDR_W-1:0] ea;
        @(negedge clk);
        eg_d = !rst && dreq && !(ireq && wins == SM);
        eg_i = !rst && ireq && !eg_d;
        ea   = eg_d ? daddr : (eg_i ? iaddr : '0);
        chk("if_gnt", {31'd0, if_gnt}, {31'd0, eg_i});
        chk("d_gnt", {31'd0, d_gnt}, {31'd0, eg_d});
        chk("mem_en", {31'd0, mem_en}, {31'd0, eg_i | eg_d});
        chk("mem_we", {28'd0, mem_we}, (eg_d && dwe) ? {28'd0, dbe} : 32'd0);
        chk("mem_addr", {22'd0, mem_addr}, {22'd0, ea});
        chk("mem_wdata", mem_wdata, (eg_i | eg_d) ? dwd : 32'd0);
        chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, !rst && pend == 1});
        chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, !rst && pend == 2});
        chk("one_rvalid", {31'd0, if_rvalid & d_rvalid}, 32'd0);
        if (!rst && pend == 1) chk("if_rdata", if_rdata, pend_data);
        if (!rst && pend == 2) chk("d_rdata", d_rdata, pend_data);
        act_i  = if_gnt;
        act_d  = d_gnt;
        last_i = eg_i;
        last_d = eg_d;
        @(posedge clk);
        if (rst) begin
            wins = 0;
            pend = 0;
        end else begin
            wins = (eg_d && ireq) ? ((wins < SM) ? wins + 1 : SM) : 0;
            pend = 0;
            if (eg_i) begin
                pend = 1; pend_data = ref_mem[iaddr[4:0]];
            end else if (eg_d && !dwe) begin
                pend = 2; pend_data = ref_mem[daddr[4:0]];
            end else if (eg_d && dwe) begin
                for (int b = 0; b < BE_W; b++)
                    if (dbe[b]) ref_mem[daddr[4:0]][8*b +: 8] = dwd[8*b +: 8];
            end
        end
        #1;
    endtask

    task automatic idle();
        ireq = 0; dreq = 0; dwe = 0; dbe = '0; iaddr = '0; daddr = '0; dwd = '0;
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        rst = 1; pre_en = 0; pre_addr = '0; pre_data = '0;
        wins = 0; pend = 0; pend_data = '0; last_i = 0; last_d = 0;
        idle();
        // Preload the RAM and the model's copy together while reset is held.
        for (int i = 0; i < 32; i++) begin
            v = (i == 4) ? 32'h00000013 : (i == 16) ? 32'h11223344 : $urandom;
            pre_en = 1; pre_addr = 5'(i); pre_data = v; ref_mem[i] = v;
            @(posedge clk); #1;
        end
        pre_en = 0;

        // 1: reset held with both requests high, then first grant goes to data
        ireq = 1; dreq = 1; iaddr = 10'h001; daddr = 10'h002;
        step(); step();
        rst = 0;
        step();
        chk("t1_first_dgnt", {31'd0, act_d}, 32'd1);
        idle(); step();

        // 2: fetch alone
        ireq = 1; iaddr = 10'h004;
        step();
        chk("t2_gnt", {31'd0, act_i}, 32'd1);
        chk("t2_rdata", if_rdata, 32'h00000013);
        idle(); step();

        // 3: partial store then load of the same word
        dreq = 1; dwe = 1; dbe = 4'b0011; daddr = 10'h010; dwd = 32'hAABBCCDD;
        step();
        dwe = 0; dbe = '0; dwd = '0;
        step();
        idle(); step();
        chk("t3_rdata", d_rdata, 32'h1122CCDD);

        // 4: persistent contention, fetch gets every fifth slot
        for (int c = 0; c < 10; c++) begin
            ireq = 1; dreq = 1; dwe = 0;
            if (c == 0 || last_i) iaddr = 10'($urandom_range(0, 31));
            daddr = 10'($urandom_range(0, 31));
            step();
            pattern[c] = act_i;
        end
        chk("t4_pattern", {22'd0, pattern}, 32'h210);
        idle(); step();

        // 5: build up starvation, load, then reset right after the load grant
        ireq = 1; dreq = 1; iaddr = 10'h003; daddr = 10'h005;
        step(); step();
        ireq = 0;
        step();
        rst = 1; idle();
        step();
        chk("t5_rvalid_in_reset", {31'd0, d_rvalid}, 32'd0);
        step();
        rst = 0;
        for (int c = 0; c < 5; c++) begin
            ireq = 1; dreq = 1; iaddr = 10'h006; daddr = 10'($urandom_range(0, 31));
            step();
            pattern[c] = act_i;
        end
        chk("t5_counter_cleared", {27'd0, pattern[4:0]}, 32'h10);
        idle(); step();

        // 6: alternating fetch and load without overlap
        for (int c = 0; c < 12; c++) begin
            idle();
            if (c % 2 == 0) begin ireq = 1; iaddr = 10'($urandom_range(0, 31)); end
            else begin dreq = 1; daddr = 10'($urandom_range(0, 31)); end
            step();
        end
        idle(); step();

        // Random traffic; the request fields are held until granted.
        last_i = 1; last_d = 1;
        for (int c = 0; c < 400; c++) begin
            if (!ireq || last_i) begin
                ireq = 1'($urandom_range(0, 1)); iaddr = 10'($urandom_range(0, 31));
            end
            if (!dreq || last_d) begin
                dreq = 1'($urandom_range(0, 1)); dwe = 1'($urandom_range(0, 1));
                dbe = 4'($urandom); daddr = 10'($urandom_range(0, 31)); dwd = $urandom;
            end
            step();
        end
        idle(); step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
